// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package reg_file_sb_pkg;

    // Default geometry: 32 x 32-bit registers, two read ports.
    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 5;
    localparam int NRD_DEF = 2;

    // MIPS register indices.
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    // An update takes effect unless it targets the hard-wired zero register.
    function automatic logic upd_ok(logic en, logic is_zero, logic zero_reg);
        return en && !(zero_reg && is_zero);
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for the register file: write port, read ports, issue port, status.
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int NRD = NRD_DEF
);
    logic              wr;
    logic [AW-1:0]     addr3;
    logic [DW-1:0]     data3;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_rdy;
    logic              iss;
    logic [AW-1:0]     iss_addr;
    logic [AW:0]       busy_cnt;

    modport master (
        output wr, addr3, data3, rd_addr, iss, iss_addr,
        input  rd_data, rd_rdy, busy_cnt
    );

    modport slave (
        input  wr, addr3, data3, rd_addr, iss, iss_addr,
        output rd_data, rd_rdy, busy_cnt
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: issue sets, write-back clears, issue wins a tie.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [AW-1:0]    clr_addr,
    input  logic             iss,
    input  logic [AW-1:0]    iss_addr,
    output logic [2**AW-1:0] busy,
    output logic [AW:0]      busy_cnt
);
    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0] busy_nxt;
    logic             clr_ok;
    logic             set_ok;

    assign clr_ok = upd_ok(wr,  clr_addr == '0, ZERO_REG != 0);
    assign set_ok = upd_ok(iss, iss_addr == '0, ZERO_REG != 0);

    // Next busy vector: clear first so a same-address issue overrides it.
    always_comb begin
        busy_nxt = busy;
        if (clr_ok) busy_nxt[clr_addr] = 1'b0;
        if (set_ok) busy_nxt[iss_addr] = 1'b1;
    end

    // Busy register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // Population count of the registered busy vector.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_cnt = busy_cnt + (AW+1)'(busy[i]);
    end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-through bypass, optional zero register and scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [DEPTH-1:0]         busy;
    logic [NRD-1:0][DW-1:0]   rd_data_v;
    logic [NRD-1:0]           rd_rdy_v;
    logic                     wr_ok;

    assign wr_ok = upd_ok(bus.wr, bus.addr3 == '0, ZERO_REG != 0);

    // Storage array; writes to the zero register are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        mem <= '0;
        else if (wr_ok) mem[bus.addr3] <= bus.data3;
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra  = bus.rd_addr[g*AW +: AW];
        // No forwarding while reset holds the array at zero.
        assign hit = wr_ok && !rst && (bus.addr3 == ra);

        // Read mux: array, then same-cycle bypass, then zero-register override.
        always_comb begin
            rd_data_v[g] = mem[ra];
            if (hit) rd_data_v[g] = bus.data3;
            if (ZERO_REG != 0 && ra == '0) rd_data_v[g] = '0;
        end

        // Operand ready if not pending, or being written this cycle.
        assign rd_rdy_v[g] = !busy[ra] || (bus.wr && bus.addr3 == ra);
    end

    assign bus.rd_data = rd_data_v;
    assign bus.rd_rdy  = rd_rdy_v;

    reg_scoreboard #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr       (bus.wr),
        .clr_addr (bus.addr3),
        .iss      (bus.iss),
        .iss_addr (bus.iss_addr),
        .busy     (busy),
        .busy_cnt (bus.busy_cnt)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Table-driven bench for reg_file_sb with an expectation queue.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DW(32), .AW(5), .NRD(2)) bus ();

    reg_file_sb #(.DW(32), .AW(5), .NRD(2), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  a3;
        logic [31:0] d3;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  erdy;
        logic [5:0]  ecnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic wr, logic [4:0] a3, logic [31:0] d3,
                                logic iss, logic [4:0] ia, logic [4:0] r0, logic [4:0] r1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] erdy,
                                logic [5:0] ecnt);
        vec_t v;
        v.wr = wr; v.a3 = a3; v.d3 = d3; v.iss = iss; v.ia = ia;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic push(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        exp_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL empty_queue got %h want <expectation>", act);
            return;
        end
        e = exp_q.pop_front();
        if (act === e.val) n_pass++;
        else $display("FAIL %s got %h want %h", e.name, act, e.val);
    endtask

    task automatic drive(input logic wr, input logic [4:0] a3, input logic [31:0] d3,
                         input logic iss, input logic [4:0] ia,
                         input logic [4:0] r0, input logic [4:0] r1);
        bus.wr       = wr;
        bus.addr3    = a3;
        bus.data3    = d3;
        bus.iss      = iss;
        bus.iss_addr = ia;
        bus.rd_addr  = {r1, r0};
    endtask

    task automatic cmp_comb();
        pop_cmp(bus.rd_data[31:0]);
        pop_cmp(bus.rd_data[63:32]);
        pop_cmp(32'(bus.rd_rdy));
    endtask

    localparam int NV = 14;
    vec_t tbl[NV];

    initial begin
        //            wr a3  d3            iss ia  r0  r1  e0            e1            rdy    cnt
        tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        2'b11, 6'd0);
        tbl[1]  = mk(0, 0,  32'h0,        0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 6'd0);
        tbl[2]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0,  5,  32'h0,        32'hDEADBEEF, 2'b11, 6'd0);
        tbl[3]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        32'h0,        2'b11, 6'd0);
        tbl[4]  = mk(0, 0,  32'h0,        1, 8,  8,  5,  32'h0,        32'hDEADBEEF, 2'b11, 6'd1);
        tbl[5]  = mk(0, 0,  32'h0,        0, 0,  8,  8,  32'h0,        32'h0,        2'b00, 6'd1);
        tbl[6]  = mk(1, 8,  32'h80,       0, 0,  8,  29, 32'h80,       32'h0,        2'b11, 6'd0);
        tbl[7]  = mk(1, 9,  32'h20,       1, 9,  9,  8,  32'h20,       32'h80,       2'b11, 6'd1);
        tbl[8]  = mk(0, 0,  32'h0,        0, 0,  9,  9,  32'h20,       32'h20,       2'b00, 6'd1);
        tbl[9]  = mk(0, 0,  32'h0,        1, 9,  9,  0,  32'h20,       32'h0,        2'b10, 6'd1);
        tbl[10] = mk(0, 0,  32'h0,        1, 0,  0,  9,  32'h0,        32'h20,       2'b01, 6'd1);
        tbl[11] = mk(1, 29, 32'h1234,     0, 0,  29, 31, 32'h1234,     32'h0,        2'b11, 6'd1);
        tbl[12] = mk(1, 9,  32'h99,       1, 31, 9,  31, 32'h99,       32'h0,        2'b11, 6'd1);
        tbl[13] = mk(0, 0,  32'h0,        0, 0,  31, 9,  32'h0,        32'h99,       2'b10, 6'd1);

        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        #3;
        push("rst_cnt", 32'd0);
        pop_cmp(32'(bus.busy_cnt));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Every register reads zero and ready after reset.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            push($sformatf("clr_r%0d_d0", i), 32'h0);
            push($sformatf("clr_r%0d_d1", i), 32'h0);
            push($sformatf("clr_r%0d_rdy", i), 32'h3);
            #1 cmp_comb();
            @(negedge clk);
        end

        // Table of writes, bypasses, issues and reads.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].wr, tbl[i].a3, tbl[i].d3, tbl[i].iss, tbl[i].ia, tbl[i].r0, tbl[i].r1);
            push($sformatf("v%0d_d0", i), tbl[i].e0);
            push($sformatf("v%0d_d1", i), tbl[i].e1);
            push($sformatf("v%0d_rdy", i), 32'(tbl[i].erdy));
            #1 cmp_comb();
            @(posedge clk);
            push($sformatf("v%0d_cnt", i), 32'(tbl[i].ecnt));
            #1 pop_cmp(32'(bus.busy_cnt));
        end

        // Issue 3, 4, 7 on top of the pending r31.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 1, (k == 0) ? 5'd3 : (k == 1) ? 5'd4 : 5'd7, 3, 7);
            @(posedge clk);
            push($sformatf("iss%0d_cnt", k), 32'(k + 2));
            #1 pop_cmp(32'(bus.busy_cnt));
        end

        // Reset between edges clears everything with no clock edge.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        drive(1, 5, 32'h55, 1, 6, 5, 29);
        push("async_cnt", 32'd0);
        push("async_d0", 32'h0);
        push("async_d1", 32'h0);
        push("async_rdy", 32'h3);
        #1 pop_cmp(32'(bus.busy_cnt));
        cmp_comb();

        // Writes and issues ignored across an edge held in reset.
        @(posedge clk);
        push("rst_edge_d0", 32'h0);
        push("rst_edge_d1", 32'h0);
        push("rst_edge_rdy", 32'h3);
        push("rst_edge_cnt", 32'd0);
        #1 cmp_comb();
        pop_cmp(32'(bus.busy_cnt));

        // First edge after release processes write and issue.
        @(negedge clk);
        rst = 1'b0;
        drive(1, 5, 32'h77, 1, 6, 6, 5);
        push("rel_d0", 32'h0);
        push("rel_d1", 32'h77);
        push("rel_rdy", 32'h3);
        #1 cmp_comb();
        @(posedge clk);
        push("rel_cnt", 32'd1);
        #1 pop_cmp(32'(bus.busy_cnt));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 5, 6);
        push("rel_rd_d0", 32'h77);
        push("rel_rd_d1", 32'h0);
        push("rel_rd_rdy", 32'h1);
        #1 cmp_comb();

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The module SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 The module SHALL have parameter AW, default 5, meaning address width; depth is 2**AW registers.
REQ-003 The module SHALL have parameter NRD, default 2, meaning number of independent read ports.
REQ-004 The module SHALL have parameter ZERO_REG, default 1, meaning 1 makes register 0 read as zero and ignore writes.
REQ-005 Port: clk  input  1  clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset; asynchronous and active-high.
REQ-007 Port: wr  input  1  write enable for the write port.
REQ-008 Port: addr3  input  AW  write address.
REQ-009 Port: data3  input  DW  write data.
REQ-010 Port: rd_addr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-011 Port: rd_data  output  NRD*DW  read data; port i occupies bits [i*DW +: DW].
REQ-012 Port: rd_rdy  output  NRD  per-port operand-ready flag (register not pending).
REQ-013 Port: iss  input  1  issue strobe; marks iss_addr pending (scoreboard set).
REQ-014 Port: iss_addr  input  AW  destination register of issuing instruction.
REQ-015 Port: busy_cnt  output  AW+1  number of registers currently pending.

Function
REQ-016 Write: on rising clk with wr=1, mem[addr3] SHALL take data3; with ZERO_REG=1 and addr3=0 the write SHALL be dropped.
REQ-017 Read: rd_data port i SHALL be combinational from rd_addr port i, zero latency.
REQ-018 Bypass: if wr=1 and addr3 equals rd_addr port i (and not the dropped zero case), rd_data port i SHALL present data3 in the same cycle.
REQ-019 With ZERO_REG=1, any read of address 0 SHALL return 0 regardless of bypass.
REQ-020 Scoreboard: one busy bit per register; iss=1 SHALL set busy[iss_addr] at the rising edge; wr=1 SHALL clear busy[addr3] at the rising edge.
REQ-021 Simultaneous iss and wr to the same address: busy SHALL end set (issue is the newer producer); data is still written.
REQ-022 With ZERO_REG=1, busy[0] SHALL never be set.
REQ-023 rd_rdy port i SHALL be 1 when busy[rd_addr i]=0, or when wr=1 and addr3 equals rd_addr i in the same cycle (bypass makes the operand available).
REQ-024 Write to a non-busy register SHALL be legal and SHALL leave busy unchanged at 0.
REQ-025 Re-issue to an already busy register SHALL leave busy set; busy_cnt SHALL not double count.
REQ-026 busy_cnt SHALL equal the population count of the busy vector after each edge; range 0..2**AW (max 2**AW-1 when ZERO_REG=1).
REQ-027 All NRD read ports SHALL operate independently; identical addresses on several ports SHALL return identical data.

Reset
REQ-028 While rst=1, every register SHALL be 0, every busy bit 0, busy_cnt 0, and writes and issues SHALL be ignored.
REQ-029 Reset asserted mid-operation SHALL clear state immediately, without waiting for clk; the first edge after deassertion SHALL process wr/iss normally.
REQ-030 During reset rd_data SHALL read 0 and rd_rdy SHALL be all ones, except where a same-cycle bypass applies; the bypass shall be suppressed while rst=1.

Structure
REQ-031 A shared package SHALL hold the default DW/AW/NRD constants and the MIPS register-index constants (ZERO=0, SP=29, RA=31).
REQ-032 The scoreboard (busy vector, set/clear priority, busy_cnt) SHALL be a sub-module named reg_scoreboard; the storage, bypass and read muxes stay in reg_file_sb.

Verification
REQ-033 Reset then read all 32 registers on both ports -> rd_data=0 and rd_rdy=1 for every register.
REQ-034 wr=1, addr3=5, data3=0xDEADBEEF, rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF combinationally; after the edge it still reads 0xDEADBEEF.
REQ-035 wr=1, addr3=0, data3=0xFFFFFFFF -> reading register 0 returns 0 both before and after the edge.
REQ-036 iss to 8 -> rd_rdy=0 on 8 and busy_cnt=1; then wr 8 with 0x80 -> rd_rdy=1 in the write cycle and busy_cnt=0 after the edge.
REQ-037 iss and wr both to 9 in the same cycle with data3=0x20 -> register 9 holds 0x20, busy[9]=1 and busy_cnt=1.
REQ-038 Issue to 3, 4 and 7, then assert rst between clock edges -> busy_cnt=0 and all registers 0 without a clock edge.
